mmcm_rc_initiator: RTL

//  Requesting side of the reconfigurable-MMCM handshake (RCREG/RCEN/RCRDY). Turns a host

---
 rtl/mmcm_rc_pkg.sv | 30 +++
 rtl/sync_bit.sv | 37 +++
 rtl/mmcm_rc_initiator.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/mmcm_rc_pkg.sv
//==============================================================================
// Module : mmcm_rc_pkg
// Brief  : State encodings, STATUS bit positions and default timeouts for the
//          MMCM reconfiguration initiator.
// Rev    : 1.0
//==============================================================================
`default_nettype none

package mmcm_rc_pkg;

    localparam logic [2:0] c_ST_IDLE      = 3'd0;
    localparam logic [2:0] c_ST_STROBE    = 3'd1;
    localparam logic [2:0] c_ST_WAIT_ACK  = 3'd2;
    localparam logic [2:0] c_ST_WAIT_DONE = 3'd3;

    localparam int c_STAT_STATE_LSB = 0;
    localparam int c_STAT_BUSY      = 3;
    localparam int c_STAT_PENDING   = 4;
    localparam int c_STAT_ACK_TO    = 5;
    localparam int c_STAT_DONE_TO   = 6;
    localparam int c_STAT_OVERRUN   = 7;
    localparam int c_STAT_CNT_LSB   = 8;

    localparam int c_DEF_ACK_TIMEOUT  = 64;
    localparam int c_DEF_DONE_TIMEOUT = 2**20;
    localparam int c_DEF_TO_W         = 21;

endpackage

`default_nettype wire

// File: rtl/sync_bit.sv
//==============================================================================
// Module : sync_bit
// Brief  : Multi-flop single-bit synchronizer, asynchronously reset to 0.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    generate
        if (STAGES < 2) begin : g_stages_check
            $error("sync_bit: STAGES must be at least 2");
        end
    endgenerate

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/mmcm_rc_initiator.sv
//==============================================================================
// Module : mmcm_rc_initiator
// Brief  : Requesting side of the RCREG/RCEN/RCRDY MMCM reconfiguration handshake.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module mmcm_rc_initiator
    import mmcm_rc_pkg::*;
#(
    parameter int CFG_WIDTH    = 576,
    parameter int SYNC_STAGES  = 2,
    parameter int ACK_TIMEOUT  = c_DEF_ACK_TIMEOUT,
    parameter int DONE_TIMEOUT = c_DEF_DONE_TIMEOUT,
    parameter int TO_W         = c_DEF_TO_W
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_req,
    input  logic [CFG_WIDTH-1:0] i_cfg_in,
    input  logic                 i_clr_err,
    input  logic                 i_rcrdy,
    output logic [CFG_WIDTH-1:0] o_rcreg,
    output logic                 o_rcen,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [15:0]          o_status
);

    generate
        if (((64'd1 << TO_W) < 64'(ACK_TIMEOUT)) || ((64'd1 << TO_W) < 64'(DONE_TIMEOUT))) begin : g_to_w_check
            $error("mmcm_rc_initiator: TO_W too small for the configured timeouts");
        end
    endgenerate

    localparam logic [TO_W-1:0] c_ACK_LAST  = TO_W'(ACK_TIMEOUT - 1);
    localparam logic [TO_W-1:0] c_DONE_LAST = TO_W'(DONE_TIMEOUT - 1);

    logic                 w_rcrdy_s;
    logic [2:0]           r_state;
    logic [2:0]           w_state_nxt;
    logic [TO_W-1:0]      r_cnt;
    logic [CFG_WIDTH-1:0] r_rcreg;
    logic                 r_rcen;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_pending;
    logic                 r_ack_to;
    logic                 r_done_to;
    logic                 r_overrun;
    logic [7:0]           r_count;
    logic [15:0]          r_status;
    logic [15:0]          w_status;

    logic w_launch;
    logic w_strobe;
    logic w_ack_fall;
    logic w_ack_to_evt;
    logic w_done_evt;
    logic w_done_to_evt;
    logic w_waiting;

    sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_sync_rcrdy (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (i_rcrdy),
        .o_q   (w_rcrdy_s)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if ((i_req || r_pending) && w_rcrdy_s) begin
                    w_state_nxt = c_ST_STROBE;
                end
            end
            c_ST_STROBE: begin
                w_state_nxt = c_ST_WAIT_ACK;
            end
            c_ST_WAIT_ACK: begin
                if (!w_rcrdy_s) begin
                    w_state_nxt = c_ST_WAIT_DONE;
                end else if (r_cnt == c_ACK_LAST) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            c_ST_WAIT_DONE: begin
                if (w_rcrdy_s || (r_cnt == c_DONE_LAST)) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    always_comb begin
        w_launch      = 1'b0;
        w_strobe      = 1'b0;
        w_ack_fall    = 1'b0;
        w_ack_to_evt  = 1'b0;
        w_done_evt    = 1'b0;
        w_done_to_evt = 1'b0;
        w_waiting     = 1'b0;
        case (r_state)
            c_ST_IDLE:      w_launch = (i_req || r_pending) && w_rcrdy_s;
            c_ST_STROBE:    w_strobe = 1'b1;
            c_ST_WAIT_ACK: begin
                w_waiting    = 1'b1;
                w_ack_fall   = !w_rcrdy_s;
                w_ack_to_evt = w_rcrdy_s && (r_cnt == c_ACK_LAST);
            end
            c_ST_WAIT_DONE: begin
                w_waiting     = 1'b1;
                w_done_evt    = w_rcrdy_s;
                w_done_to_evt = !w_rcrdy_s && (r_cnt == c_DONE_LAST);
            end
            default: ;
        endcase
    end

    // Snapshot, strobe, timeout counter and handshake flags.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rcreg   <= '0;
            r_rcen    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_cnt     <= '0;
            r_pending <= 1'b0;
            r_count   <= 8'd0;
        end else begin
            r_rcen    <= w_strobe;
            r_done    <= w_done_evt;
            r_pending <= w_launch ? 1'b0 : (r_pending || i_req);
            if (w_launch) begin
                r_rcreg <= i_cfg_in;
            end
            if (w_launch) begin
                r_busy <= 1'b1;
            end else if (w_ack_to_evt || w_done_evt || w_done_to_evt) begin
                r_busy <= 1'b0;
            end
            if (w_strobe || w_ack_fall) begin
                r_cnt <= '0;
            end else if (w_waiting && (r_cnt != '1)) begin
                r_cnt <= r_cnt + TO_W'(1);
            end
            if (w_done_evt) begin
                r_count <= r_count + 8'd1;
            end
        end
    end

    // Sticky errors: a set in the same cycle as the clear takes priority.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ack_to  <= 1'b0;
            r_done_to <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_ack_to  <= w_ack_to_evt       || (r_ack_to  && !i_clr_err);
            r_done_to <= w_done_to_evt      || (r_done_to && !i_clr_err);
            r_overrun <= (i_req && r_pending) || (r_overrun && !i_clr_err);
        end
    end

    always_comb begin
        w_status                          = '0;
        w_status[c_STAT_STATE_LSB +: 3]   = r_state;
        w_status[c_STAT_BUSY]             = r_busy;
        w_status[c_STAT_PENDING]          = r_pending;
        w_status[c_STAT_ACK_TO]           = r_ack_to;
        w_status[c_STAT_DONE_TO]          = r_done_to;
        w_status[c_STAT_OVERRUN]          = r_overrun;
        w_status[c_STAT_CNT_LSB +: 8]     = r_count;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_status <= 16'd0;
        end else begin
            r_status <= w_status;
        end
    end

    assign o_rcreg  = r_rcreg;
    assign o_rcen   = r_rcen;
    assign o_busy   = r_busy;
    assign o_done   = r_done;
    assign o_status = r_status;

endmodule

`default_nettype wire
